// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture and generator blocks.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } pwm_cap_state_t;

   // Tick interval in clocks for a given prescale: max(prescale>>1, 1).
   function automatic logic [31:0] half_prescale(input logic [31:0] prescale);
      logic [31:0] half;
      half = prescale >> 1;
      return (half == 32'd0) ? 32'd1 : half;
   endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Control inputs and measurement results of pwm_capture; the DUT connects through the slave modport.
interface pwm_capture_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  en;
   logic [DATA_WIDTH-1:0] prescale;
   logic                  in;
   logic [DATA_WIDTH-1:0] high_count;
   logic [DATA_WIDTH-1:0] period_count;
   logic                  valid;
   logic                  saturated;
   logic                  stuck_high;
   logic                  stuck_low;
   logic                  window;

   modport master (
      output en, prescale, in,
      input  high_count, period_count, valid, saturated, stuck_high, stuck_low, window
   );

   modport slave (
      input  en, prescale, in,
      output high_count, period_count, valid, saturated, stuck_high, stuck_low, window
   );
endinterface

// File: rtl/pwm_prescaler.sv
// Restartable tick generator: one tick every max(prescale>>1,1) clocks after the last restart.
module pwm_prescaler
   import pwm_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  restart,
   input  logic [DATA_WIDTH-1:0] prescale,
   output logic                  tick
);
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d, last;
   logic [31:0]           half;

   // >= keeps the divider from wrapping when prescale shrinks mid-count.
   always_comb begin
      half  = half_prescale(32'(prescale));
      last  = DATA_WIDTH'(half - 32'd1);
      tick  = en && (cnt_q >= last);
      cnt_d = cnt_q + DATA_WIDTH'(1);
      if (!en || restart || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/pwm_capture.sv
// PWM capture: reports high time and period in prescaled ticks once per rising-to-rising period.
// Define PWM_CAPTURE_WINDOW_EN to build the mid-high-time window output (tied to 0 otherwise).
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PADDING     = 30
) (
   input logic          clk,
   input logic          rst_n,
   pwm_capture_if.slave bus
);
   localparam logic [DATA_WIDTH-1:0] CNT_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q, rise_q, fall_q, tick;
   pwm_cap_state_t         state_q;
   logic [DATA_WIDTH-1:0]  hcnt_q, pcnt_q, hcnt_d, pcnt_d;
   logic [DATA_WIDTH-1:0]  high_count_q, period_count_q;
   logic                   valid_q, saturated_q, stuck_high_q, stuck_low_q, window;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("SYNC_STAGES must be at least 2");
   end
   if (PADDING < 0) begin : g_bad_padding
      $error("PADDING must be non-negative");
   end

   // NOTE: synchronizer and level history carry no reset, so a pin held high through reset is not mistaken for a new rising edge.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.in};
      last_q <= sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= sync_q[SYNC_STAGES-1] & ~last_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & last_q;
      end
   end

   pwm_prescaler #(.DATA_WIDTH(DATA_WIDTH)) u_prescaler (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en),
      .restart  (rise_q),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   // Saturating increments; the tick of the edge cycle belongs to the period that edge closes.
   always_comb begin
      hcnt_d = hcnt_q;
      pcnt_d = pcnt_q;
      if (tick && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + DATA_WIDTH'(1);
      if (tick && (pcnt_q != CNT_MAX)) pcnt_d = pcnt_q + DATA_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         hcnt_q         <= '0;
         pcnt_q         <= '0;
         high_count_q   <= '0;
         period_count_q <= '0;
         valid_q        <= 1'b0;
         saturated_q    <= 1'b0;
         stuck_high_q   <= 1'b0;
         stuck_low_q    <= 1'b0;
      end else if (!bus.en) begin
         state_q      <= IDLE;
         hcnt_q       <= '0;
         pcnt_q       <= '0;
         valid_q      <= 1'b0;
         stuck_high_q <= 1'b0;
         stuck_low_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise_q) begin
                  state_q <= HIGH;
                  hcnt_q  <= '0;
                  pcnt_q  <= '0;
               end
            end
            HIGH: begin
               hcnt_q <= hcnt_d;
               pcnt_q <= pcnt_d;
               if (hcnt_d == CNT_MAX) stuck_high_q <= 1'b1;
               if (fall_q) begin
                  state_q      <= LOW;
                  stuck_high_q <= 1'b0;
               end
            end
            LOW: begin
               if (rise_q) begin
                  state_q        <= HIGH;
                  high_count_q   <= hcnt_q;
                  period_count_q <= pcnt_d;
                  saturated_q    <= (pcnt_d == CNT_MAX) || (hcnt_q == CNT_MAX);
                  valid_q        <= 1'b1;
                  stuck_low_q    <= 1'b0;
                  hcnt_q         <= '0;
                  pcnt_q         <= '0;
               end else begin
                  pcnt_q <= pcnt_d;
                  if (pcnt_d == CNT_MAX) stuck_low_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef PWM_CAPTURE_WINDOW_EN
   // Decoded from registered state only, so it follows hcnt_q cycle for cycle.
   always_comb begin
      window = 1'b0;
      if ((state_q == HIGH) && (int'(high_count_q) > 2 * PADDING) &&
          (int'(hcnt_q) >= PADDING) && (int'(hcnt_q) <= int'(high_count_q) - PADDING))
         window = 1'b1;
   end
`else
   assign window = 1'b0;
`endif

   assign bus.high_count   = high_count_q;
   assign bus.period_count = period_count_q;
   assign bus.valid        = valid_q;
   assign bus.saturated    = saturated_q;
   assign bus.stuck_high   = stuck_high_q;
   assign bus.stuck_low    = stuck_low_q;
   assign bus.window       = window;
endmodule

// File: tb/tb_pwm_capture.sv
// Directed self-checking bench for pwm_capture with hand-computed tick counts.
module tb_pwm_capture;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   vcount = 0;
   int   wcount = 0;
   int   dbl    = 0;
   logic prev_valid = 1'b0;
   int   cap_high   = 0;
   int   cap_period = 0;
   int   cap_sat    = 0;

   pwm_capture_if #(.DATA_WIDTH(8)) bus ();

   pwm_capture #(
      .DATA_WIDTH  (8),
      .SYNC_STAGES (2),
      .PADDING     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.valid) begin
         vcount++;
         cap_high   = int'(bus.high_count);
         cap_period = int'(bus.period_count);
         cap_sat    = int'(bus.saturated);
      end
      if (bus.valid && prev_valid) dbl++;
      if (bus.window) wcount++;
      prev_valid = bus.valid;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      bus.in = lvl;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic period(input int h, input int l);
      drive(1'b1, h);
      drive(1'b0, l);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"},  int'(bus.valid), 0);
      check({tag, "_high"},   int'(bus.high_count), 0);
      check({tag, "_period"}, int'(bus.period_count), 0);
      check({tag, "_sat"},    int'(bus.saturated), 0);
      check({tag, "_sth"},    int'(bus.stuck_high), 0);
      check({tag, "_stl"},    int'(bus.stuck_low), 0);
      check({tag, "_win"},    int'(bus.window), 0);
   endtask

   initial begin
      int   v0;
      int   lat;
      logic seen;

      rst_n        = 1'b0;
      bus.en       = 1'b0;
      bus.in       = 1'b0;
      bus.prescale = 8'd2;
      repeat (4) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n  = 1'b1;
      bus.en = 1'b1;

      // prescale=2: 10-clock period, 3 high; first rise only arms the FSM
      v0 = vcount;
      repeat (4) period(3, 7);
      check("p2_nvalid", vcount - v0, 3);
      check("p2_high",   cap_high, 3);
      check("p2_period", cap_period, 10);
      check("p2_sat",    cap_sat, 0);

      // latency from first sampling edge to valid
      bus.in = 1'b1;
      lat    = 0;
      seen   = 1'b0;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.valid) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      check("latency", lat, 4);
      @(posedge clk);
      #1;
      drive(1'b0, 7);

      // prescale=8: 40-clock period, 20 high -> 5 / 10 ticks
      bus.prescale = 8'd8;
      v0 = vcount;
      repeat (4) period(20, 20);
      check("p8_nvalid", vcount - v0, 4);
      check("p8_high",   cap_high, 5);
      check("p8_period", cap_period, 10);
      check("p8_sat",    cap_sat, 0);

      // long low: stuck_low after 255 ticks, next rise publishes saturated period
      bus.prescale = 8'd2;
      period(3, 7);
      v0 = vcount;
      drive(1'b1, 3);
      drive(1'b0, 250);
      check("stl_early", int'(bus.stuck_low), 0);
      drive(1'b0, 10);
      check("stl_set", int'(bus.stuck_low), 1);
      drive(1'b0, 37);
      period(3, 7);
      check("stl_nvalid", vcount - v0, 2);
      check("stl_period", cap_period, 255);
      check("stl_high",   cap_high, 3);
      check("stl_sat",    cap_sat, 1);
      check("stl_clear",  int'(bus.stuck_low), 0);

      // long high: stuck_high sets, fall clears it, next rise publishes 255/255
      v0 = vcount;
      drive(1'b1, 250);
      check("sth_early", int'(bus.stuck_high), 0);
      drive(1'b1, 50);
      check("sth_set", int'(bus.stuck_high), 1);
      drive(1'b0, 5);
      check("sth_clear", int'(bus.stuck_high), 0);
      period(3, 7);
      check("sth_nvalid", vcount - v0, 2);
      check("sth_high",   cap_high, 255);
      check("sth_period", cap_period, 255);
      check("sth_sat",    cap_sat, 1);

      // reset mid-high-time
      period(4, 5);
      drive(1'b1, 6);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_all_zero("midrst");
      v0 = vcount;
      drive(1'b1, 3);
      drive(1'b0, 7);
      period(3, 7);
      check("midrst_nopub", vcount - v0, 0);
      period(3, 7);
      check("midrst_pub",    vcount - v0, 1);
      check("midrst_high",   cap_high, 3);
      check("midrst_period", cap_period, 10);

      // en low mid-high-time: flags drop, results hold (high 4, period 9)
      period(4, 5);
      drive(1'b1, 6);
      bus.en = 1'b0;
      @(posedge clk);
      #1;
      check("en_valid",  int'(bus.valid), 0);
      check("en_sth",    int'(bus.stuck_high), 0);
      check("en_stl",    int'(bus.stuck_low), 0);
      check("en_win",    int'(bus.window), 0);
      check("en_high",   int'(bus.high_count), 4);
      check("en_period", int'(bus.period_count), 9);
      check("en_sat",    int'(bus.saturated), 0);
      bus.en = 1'b1;
      v0 = vcount;
      drive(1'b1, 3);
      drive(1'b0, 7);
      period(3, 7);
      check("en_nopub", vcount - v0, 0);
      period(3, 7);
      check("en_pub",    vcount - v0, 1);
      check("en_high2",  cap_high, 3);
      check("en_period2", cap_period, 10);

      // window: steady high of 8 ticks with PADDING=2 -> hcnt 2..6, five cycles
      repeat (3) period(8, 4);
      wcount = 0;
      period(8, 4);
`ifdef PWM_CAPTURE_WINDOW_EN
      check("window_cycles", wcount, 5);
`else
      check("window_cycles", wcount, 0);
`endif

      check("no_back_to_back_valid", dbl, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
